// File: rtl/counter_load_sequencer_if.sv
// Producer, host and Counter-side signals of the load sequencer.
// The slave modport is the sequencer side and the master modport is the environment side.
interface counter_load_sequencer_if #(
    parameter int WORDSIZE = 8,
    parameter int DEPTH    = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                valid;
    logic [WORDSIZE-1:0] value;
    logic                accept;
    logic                start;
    logic                abort;
    logic                load;
    logic [WORDSIZE-1:0] counter;
    logic                enable;
    logic                ready;
    logic                done;
    logic                busy;
    logic [LW-1:0]       level;
    logic                overflow;

    modport master (
        output valid, value, start, abort, ready,
        input  accept, load, counter, enable, done, busy, level, overflow
    );

    modport slave (
        input  valid, value, start, abort, ready,
        output accept, load, counter, enable, done, busy, level, overflow
    );
endinterface

// File: rtl/counter_load_sequencer.sv
// Queues preset values in a small FIFO and sequences them into Counter (load, enable, wait ready).
// Optional feature: define SEQ_AUTORELOAD_EN to repeat the last value when the FIFO runs dry.
module counter_load_sequencer #(
    parameter int WORDSIZE = 8,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    counter_load_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_t;

    state_t              state_q, state_d;
    logic [WORDSIZE-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level_q;
    logic [WORDSIZE-1:0] counter_q;
    logic                done_q, done_d;
    logic                overflow_q;
    logic                accept, push, pop, have_data;

    assign accept    = (level_q != LW'(DEPTH));
    assign push      = bus.valid & accept;
    assign have_data = (level_q != '0);

    // Storage has no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (bus.valid && !accept) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (pop) counter_q <= mem[rd_ptr];
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && have_data) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end
                end
                LOAD: state_d = ARM;
                // Counter is still settling from the load, so ready is not looked at here.
                ARM:  state_d = RUN;
                RUN: begin
                    if (bus.ready) begin
                        done_d = 1'b1;
                        if (bus.start && have_data) begin
                            pop     = 1'b1;
                            state_d = LOAD;
                        end
`ifdef SEQ_AUTORELOAD_EN
                        else if (bus.start) begin
                            state_d = LOAD;
                        end
`endif
                        else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.accept   = accept;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.counter  = counter_q;
    assign bus.done     = done_q;
    assign bus.load     = (state_q == LOAD);
    assign bus.enable   = (state_q == ARM) || (state_q == RUN);
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_counter_load_sequencer.sv
// Bench for counter_load_sequencer: queue-based reference checked every cycle plus directed literals.
module tb_counter_load_sequencer;
    localparam int W = 8;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    counter_load_sequencer_if #(.WORDSIZE(W), .DEPTH(D)) bus_if ();

    counter_load_sequencer #(.WORDSIZE(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: FIFO is a queue; phase counts cycles since the load (0 idle, 1 load, 2 arm, 3 run).
    int         mq[$];
    int         m_phase = 0;
    logic [W-1:0] m_counter = '0;
    logic       m_done = 1'b0;
    logic       m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_phase   = 0;
            m_counter = '0;
            m_done    = 1'b0;
            m_ovf     = 1'b0;
        end else begin
            int  pre;
            bit  do_pop;
            pre    = mq.size();
            do_pop = 0;
            m_done = 1'b0;
            if (bus_if.valid && pre == D) m_ovf = 1'b1;
            if (bus_if.abort) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (bus_if.start && pre > 0) begin do_pop = 1; m_phase = 1; end
            end else if (m_phase < 3) begin
                m_phase++;
            end else if (bus_if.ready) begin
                m_done = 1'b1;
                if (bus_if.start && pre > 0) begin do_pop = 1; m_phase = 1; end
`ifdef SEQ_AUTORELOAD_EN
                else if (bus_if.start) m_phase = 1;
`endif
                else m_phase = 0;
            end
            if (do_pop) m_counter = W'(mq.pop_front());
            if (bus_if.valid && pre < D) mq.push_back(int'(bus_if.value));
        end
    end

    always @(negedge clk) begin
        chk("accept",   32'(bus_if.accept),   32'(mq.size() < D));
        chk("level",    32'(bus_if.level),    32'(mq.size()));
        chk("load",     32'(bus_if.load),     32'(m_phase == 1));
        chk("enable",   32'(bus_if.enable),   32'(m_phase >= 2));
        chk("busy",     32'(bus_if.busy),     32'(m_phase != 0));
        chk("done",     32'(bus_if.done),     32'(m_done));
        chk("overflow", 32'(bus_if.overflow), 32'(m_ovf));
        chk("counter",  32'(bus_if.counter),  32'(m_counter));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        bus_if.valid = 1'b0;
        bus_if.abort = 1'b0;
        bus_if.start = 1'b0;
        bus_if.ready = 1'b1;
        repeat (4) tick();
        bus_if.ready = 1'b0;
    endtask

    initial begin
        int nl;
        logic [W-1:0] seq [4];
        bus_if.valid = 1'b0;
        bus_if.value = '0;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        bus_if.ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_accept", 32'(bus_if.accept), 32'd1);
        chk("rst_level",  32'(bus_if.level),  32'd0);
        chk("rst_busy",   32'(bus_if.busy),   32'd0);
        rst_n = 1'b1;
        tick();

        // Single run
        bus_if.valid = 1'b1; bus_if.value = 8'h05; bus_if.start = 1'b1;
        tick();
        bus_if.valid = 1'b0;
        chk("single_level", 32'(bus_if.level), 32'd1);
        chk("single_noload_yet", 32'(bus_if.load), 32'd0);
        tick();
        chk("single_load", 32'(bus_if.load), 32'd1);
        chk("single_cnt",  32'(bus_if.counter), 32'h05);
        tick();
        chk("single_arm_en", 32'(bus_if.enable), 32'd1);
        bus_if.ready = 1'b1;
        tick();
        chk("single_run_en", 32'(bus_if.enable), 32'd1);
        chk("single_arm_nodone", 32'(bus_if.done), 32'd0);
        tick();
        chk("single_done", 32'(bus_if.done), 32'd1);
        chk("single_en_off", 32'(bus_if.enable), 32'd0);
        settle();

        // Fill, overflow, back-to-back
        foreach (seq[i]) seq[i] = '0;
        bus_if.valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus_if.value = W'(i * 8'h11);
            tick();
        end
        chk("full_accept", 32'(bus_if.accept), 32'd0);
        chk("full_level",  32'(bus_if.level),  32'd4);
        bus_if.value = 8'h55;
        tick();
        bus_if.valid = 1'b0;
        chk("ovf_set",   32'(bus_if.overflow), 32'd1);
        chk("ovf_level", 32'(bus_if.level),    32'd4);
        bus_if.start = 1'b1; bus_if.ready = 1'b1;
        nl = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_if.load) begin
                if (nl < 4) begin
                    seq[nl] = bus_if.counter;
                    chk("b2b_done_with_load", 32'(bus_if.done), 32'(nl > 0));
                end
                nl++;
            end
        end
        for (int i = 0; i < 4; i++) chk("b2b_order", 32'(seq[i]), 32'((i + 1) * 8'h11));
`ifdef SEQ_AUTORELOAD_EN
        chk("b2b_count_ge4", 32'(nl >= 4), 32'd1);
`else
        chk("b2b_count", 32'(nl), 32'd4);
`endif
        settle();

        // Abort in ARM with ready high
        bus_if.valid = 1'b1; bus_if.value = 8'h66; tick();
        bus_if.value = 8'h77; tick();
        bus_if.valid = 1'b0;
        bus_if.start = 1'b1; tick();
        chk("abort_load_cnt", 32'(bus_if.counter), 32'h66);
        tick();
        bus_if.abort = 1'b1; bus_if.ready = 1'b1; tick();
        chk("abort_busy",  32'(bus_if.busy),  32'd0);
        chk("abort_done",  32'(bus_if.done),  32'd0);
        chk("abort_level", 32'(bus_if.level), 32'd1);
        bus_if.abort = 1'b0; bus_if.ready = 1'b0; tick();
        chk("abort_next_load", 32'(bus_if.load),    32'd1);
        chk("abort_next_cnt",  32'(bus_if.counter), 32'h77);
        settle();

        // Simultaneous push and pop at level 1
        bus_if.valid = 1'b1; bus_if.value = 8'h88; tick();
        bus_if.value = 8'h99; bus_if.start = 1'b1; tick();
        bus_if.valid = 1'b0;
        chk("pp_level", 32'(bus_if.level),   32'd1);
        chk("pp_cnt",   32'(bus_if.counter), 32'h88);
        bus_if.ready = 1'b1;
        repeat (3) tick();
        chk("pp_next_load", 32'(bus_if.load),    32'd1);
        chk("pp_next_cnt",  32'(bus_if.counter), 32'h99);
        settle();

        // Autoreload behaviour with a single value
        bus_if.valid = 1'b1; bus_if.value = 8'h03; tick();
        bus_if.valid = 1'b0;
        bus_if.start = 1'b1; bus_if.ready = 1'b1;
        nl = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus_if.load) begin
                chk("auto_cnt", 32'(bus_if.counter), 32'h03);
                nl++;
            end
        end
`ifdef SEQ_AUTORELOAD_EN
        chk("auto_repeats", 32'(nl >= 3), 32'd1);
`else
        chk("auto_once", 32'(nl), 32'd1);
        chk("auto_idle", 32'(bus_if.busy), 32'd0);
`endif
        settle();

        // Asynchronous reset mid-run
        bus_if.valid = 1'b1; bus_if.value = 8'hAA; tick();
        bus_if.value = 8'hBB; bus_if.start = 1'b1; tick();
        bus_if.valid = 1'b0;
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_accept",  32'(bus_if.accept),   32'd1);
        chk("mrst_level",   32'(bus_if.level),    32'd0);
        chk("mrst_busy",    32'(bus_if.busy),     32'd0);
        chk("mrst_enable",  32'(bus_if.enable),   32'd0);
        chk("mrst_counter", 32'(bus_if.counter),  32'd0);
        chk("mrst_ovf",     32'(bus_if.overflow), 32'd0);
        tick();
        bus_if.start = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
